// File: rtl/pulp_cluster_dma_pkg.sv
// Shared types for the pulp_cluster DMA copy engine: FSM encoding, DMA size codes
// and the request descriptor driven on both ctrl channels.
package pulp_cluster_dma_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_REQ = 4'd1,
    RD_DAT = 4'd2,
    WR_REQ = 4'd3,
    WR_DAT = 4'd4,
    DONE   = 4'd5
  } dma_state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [2:0] SIZE_DWORD = 3'b011;
  localparam int unsigned STALL_W   = 28;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] length;
    logic [2:0]  size;
    logic [4:0]  user;
  } dma_ctrl_t;

  function automatic logic [2:0] dma_size(input int unsigned w);
    return (w == 64) ? SIZE_DWORD : SIZE_WORD;
  endfunction

endpackage

// File: rtl/pulp_cluster_dma_fifo.sv
// First-word-fall-through FIFO: the head entry is presented on rdata as soon as
// the FIFO is non-empty, so a push is visible the following cycle.
module pulp_cluster_dma_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulp_cluster_rtl_dma_copy.sv
// ESP DMA memory-to-memory copy: read a chunk into the FIFO, write it back, repeat.
// Optional stall counter on debug[31:4] with PULP_CLUSTER_DMA_PERF_CNT_EN.
module pulp_cluster_rtl_dma_copy
  import pulp_cluster_dma_pkg::*;
#(
  parameter int DMA_W = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conf_done,
  input  logic [31:0]      conf_info_reg1,
  input  logic [31:0]      conf_info_reg2,
  input  logic [31:0]      conf_info_reg3,
  input  logic             dma_read_ctrl_ready,
  output logic             dma_read_ctrl_valid,
  output logic [31:0]      dma_read_ctrl_data_index,
  output logic [31:0]      dma_read_ctrl_data_length,
  output logic [2:0]       dma_read_ctrl_data_size,
  output logic [4:0]       dma_read_ctrl_data_user,
  input  logic             dma_read_chnl_valid,
  input  logic [DMA_W-1:0] dma_read_chnl_data,
  output logic             dma_read_chnl_ready,
  input  logic             dma_write_ctrl_ready,
  output logic             dma_write_ctrl_valid,
  output logic [31:0]      dma_write_ctrl_data_index,
  output logic [31:0]      dma_write_ctrl_data_length,
  output logic [2:0]       dma_write_ctrl_data_size,
  output logic [4:0]       dma_write_ctrl_data_user,
  output logic             dma_write_chnl_valid,
  output logic [DMA_W-1:0] dma_write_chnl_data,
  input  logic             dma_write_chnl_ready,
  output logic             acc_done,
  output logic [31:0]      debug
);

  dma_state_e  state;
  logic [31:0] n_tot, rb, wb, cnt, len, beat;
  logic [31:0] remain, len_nxt, cnt_nxt;
  logic        fifo_full, fifo_empty;
  logic        rd_hs, wr_hs, last_beat;
  dma_ctrl_t   rd_req, wr_req;

  assign remain    = n_tot - cnt;
  assign len_nxt   = (remain > 32'(CHUNK)) ? 32'(CHUNK) : remain;
  assign cnt_nxt   = cnt + len;
  assign last_beat = (beat == len - 32'd1);

  assign rd_req = '{index: rb + cnt, length: len_nxt, size: dma_size(DMA_W), user: 5'd0};
  assign wr_req = '{index: wb + cnt, length: len,     size: dma_size(DMA_W), user: 5'd0};

  assign dma_read_ctrl_valid        = (state == RD_REQ);
  assign dma_read_ctrl_data_index   = rd_req.index;
  assign dma_read_ctrl_data_length  = rd_req.length;
  assign dma_read_ctrl_data_size    = rd_req.size;
  assign dma_read_ctrl_data_user    = rd_req.user;
  assign dma_write_ctrl_valid       = (state == WR_REQ);
  assign dma_write_ctrl_data_index  = wr_req.index;
  assign dma_write_ctrl_data_length = wr_req.length;
  assign dma_write_ctrl_data_size   = wr_req.size;
  assign dma_write_ctrl_data_user   = wr_req.user;

  assign dma_read_chnl_ready  = (state == RD_DAT) && !fifo_full;
  assign dma_write_chnl_valid = (state == WR_DAT) && !fifo_empty;
  assign rd_hs = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_hs = dma_write_chnl_valid && dma_write_chnl_ready;

  pulp_cluster_dma_fifo #(.W(DMA_W), .DEPTH(CHUNK)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_hs),
    .wdata (dma_read_chnl_data),
    .pop   (wr_hs),
    .rdata (dma_write_chnl_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n_tot    <= '0;
      rb       <= '0;
      wb       <= '0;
      cnt      <= '0;
      len      <= '0;
      beat     <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_done <= (state == DONE);
      case (state)
        IDLE: if (conf_done) begin
          n_tot <= conf_info_reg1;
          rb    <= conf_info_reg2;
          wb    <= conf_info_reg3;
          cnt   <= '0;
          beat  <= '0;
          state <= (conf_info_reg1 == '0) ? DONE : RD_REQ;
        end
        RD_REQ: if (dma_read_ctrl_ready) begin
          len   <= len_nxt;
          beat  <= '0;
          state <= RD_DAT;
        end
        RD_DAT: if (rd_hs) begin
          beat <= last_beat ? '0 : beat + 32'd1;
          if (last_beat) state <= WR_REQ;
        end
        WR_REQ: if (dma_write_ctrl_ready) state <= WR_DAT;
        WR_DAT: if (wr_hs) begin
          beat <= last_beat ? '0 : beat + 32'd1;
          if (last_beat) begin
            cnt   <= cnt_nxt;
            state <= (cnt_nxt == n_tot) ? DONE : RD_REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PULP_CLUSTER_DMA_PERF_CNT_EN
  logic [STALL_W-1:0] stall_cnt;
  logic               stall;

  assign stall = ((state == RD_DAT) && dma_read_chnl_valid && !dma_read_chnl_ready) ||
                 ((state == WR_DAT) && dma_write_chnl_valid && !dma_write_chnl_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           stall_cnt <= '0;
    else if (state == IDLE && conf_done) stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
  end

  assign debug = {stall_cnt, state};
`else
  assign debug = {28'd0, state};
`endif

endmodule

// File: doc/pulp_cluster_rtl_dma_copy.md
Name: pulp_cluster_rtl_dma_copy

Overview:
- Parametrised successor of the pulp_cluster RTL DMA accelerator shell; performs a real memory-to-memory copy over the ESP DMA interface.
- After conf_done, reads the job's words in chunks through dma_read, buffers each chunk in an internal FIFO, then writes the chunk back through dma_write.
- Raises acc_done when the job completes.
- Sits directly under the ESP accelerator socket wrapper, replacing the stub.

Parameters:
- DMA_W, 32, DMA beat width in bits; 32 or 64 only.
- CHUNK, 16, maximum words per DMA burst; also the FIFO depth; power of two, 2..256.

Ports:
- clk  input  1  accelerator clock.
- rst  input  1  asynchronous, active-low reset.
- conf_done  input  1  one-cycle pulse; configuration registers are valid.
- conf_info_reg1  input  32  total words to copy (N).
- conf_info_reg2  input  32  read base index, in beats.
- conf_info_reg3  input  32  write base index, in beats.
- dma_read_ctrl_valid / dma_read_ctrl_ready  output / input  1 / 1  read request handshake.
- dma_read_ctrl_data_index, dma_read_ctrl_data_length  output  32 each  burst start index and burst length, in beats.
- dma_read_ctrl_data_size  output  3  3'b010 when DMA_W=32; 3'b011 when DMA_W=64.
- dma_read_ctrl_data_user  output  5  constant 0.
- dma_read_chnl_valid / dma_read_chnl_data / dma_read_chnl_ready  input / input / output  1 / DMA_W / 1  read data stream.
- dma_write_ctrl_valid / dma_write_ctrl_ready  output / input  1 / 1  write request handshake.
- dma_write_ctrl_data_index, dma_write_ctrl_data_length  output  32 each; dma_write_ctrl_data_size  output  3; dma_write_ctrl_data_user  output  5; same encoding as the read side.
- dma_write_chnl_valid / dma_write_chnl_data / dma_write_chnl_ready  output / output / input  1 / DMA_W / 1  write data stream.
- acc_done  output  1  one-cycle completion pulse.
- debug  output  32  status word.

Behaviour:
- Reset (asynchronous assert on rst low, synchronous release):
  - All valid outputs = 0, acc_done = 0, debug = 0.
  - Counters and FIFO cleared; FSM in IDLE.
- Handshakes: a transfer occurs in any cycle where valid && ready. Once valid is asserted, it and its data are held stable until the transfer.
- FSM states and transitions:
  - IDLE: on conf_done, latch N, read base (rb) and write base (wb); clear the done-word counter (cnt). If N == 0, go to DONE; otherwise go to RD_REQ.
  - RD_REQ: drive read ctrl valid with index = rb + cnt and len = min(CHUNK, N - cnt). On handshake, go to RD_DAT.
  - RD_DAT: dma_read_chnl_ready = 1 only in this state and only while the FIFO is not full. Push every accepted beat into the FIFO. After len beats, go to WR_REQ.
  - WR_REQ: write ctrl valid with index = wb + cnt and the same len. On handshake, go to WR_DAT.
  - WR_DAT: dma_write_chnl_valid = FIFO not empty; data = FIFO head; pop on handshake. After len beats, cnt += len; go to DONE if cnt == N, else to RD_REQ.
  - DONE: acc_done = 1 for exactly one cycle, then go to IDLE.
- Timing: the FIFO is first-word fall-through, so the head is visible the cycle after the push. The FSM adds no bubble between consecutive beats when valid and ready are both held high.
- Arithmetic: all index and length arithmetic is 32-bit unsigned and wraps modulo 2^32 without error. The final burst is shorter when N is not a multiple of CHUNK.
- conf_done outside IDLE is ignored.
- Reset mid-burst aborts the job immediately; no acc_done is issued.
- dma_read_chnl_valid outside RD_DAT is never accepted (ready = 0).
- debug[3:0] = FSM state code; debug[31:4] = 0, unless the optional feature below is compiled in.

Optional Feature:
- Macro: PULP_CLUSTER_DMA_PERF_CNT_EN.
- Defined:
  - debug[31:4] = count of cycles spent in RD_DAT or WR_DAT with valid high and ready low (stall cycles), saturating at 2^28-1.
  - The counter clears on conf_done.
- Undefined: debug[31:4] is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package pulp_cluster_dma_pkg holds:
  - FSM state enum: IDLE=0, RD_REQ=1, RD_DAT=2, WR_REQ=3, WR_DAT=4, DONE=5.
  - DMA size constants SIZE_WORD=3'b010 and SIZE_DWORD=3'b011.
  - A function mapping DMA_W to the size code.
- One natural sub-module, pulp_cluster_dma_fifo: synchronous first-word-fall-through FIFO, parameters W and DEPTH, with full/empty flags.

Test Plan:
- DMA_W=32, CHUNK=16, N=40, rb=0x100, wb=0x800, always-ready memory model:
  - Read requests: (0x100,16), (0x110,16), (0x120,8).
  - Matching write requests at 0x800/0x810/0x820.
  - Destination data equals source data; exactly one acc_done pulse.
- N=0: acc_done goes high 2 cycles after conf_done; no ctrl valid is ever asserted.
- Random back-pressure on read_chnl_valid and write_chnl_ready (50%), N=37: data order preserved, no beat lost or duplicated, FIFO never overflows.
- DMA_W=64, N=5, CHUNK=4: data_size=3'b011 on both sides; burst lengths 4 then 1.
- Reset asserted during WR_DAT of the second burst:
  - All valids drop in the same cycle and acc_done stays 0.
  - A new conf_done then runs a complete job correctly.
- With PULP_CLUSTER_DMA_PERF_CNT_EN defined and write_chnl_ready held low for 10 cycles in WR_DAT: debug[31:4] == 10.
